// File: rtl/vga_timing_pkg.sv
// Shared SVGA 800x600 timing constants, scan-phase type and coordinate types
// for the VGA raster timing generator and its axis counters.
package vga_timing_pkg;

  localparam int SVGA_H_VISIBLE = 800;
  localparam int SVGA_H_FP      = 56;
  localparam int SVGA_H_SYNC    = 120;
  localparam int SVGA_H_BP      = 64;
  localparam int SVGA_V_VISIBLE = 600;
  localparam int SVGA_V_FP      = 37;
  localparam int SVGA_V_SYNC    = 6;
  localparam int SVGA_V_BP      = 23;

  // Length of one axis period (pixels per line or lines per frame).
  function automatic int axis_total(input int vis, input int fp, input int sync, input int bp);
    return vis + fp + sync + bp;
  endfunction

  localparam int SVGA_H_TOTAL = axis_total(SVGA_H_VISIBLE, SVGA_H_FP, SVGA_H_SYNC, SVGA_H_BP);
  localparam int SVGA_V_TOTAL = axis_total(SVGA_V_VISIBLE, SVGA_V_FP, SVGA_V_SYNC, SVGA_V_BP);

  typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} scan_phase_t;

  typedef logic [10:0] h_coord_t;
  typedef logic [9:0]  v_coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// Count, phase, sync and visible are registered together so they never skew.
// wrap is combinational: high in the advance cycle that takes count back to 0.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   CW      = 11,
  parameter int   VISIBLE = 800,
  parameter int   FP      = 56,
  parameter int   SYNC    = 120,
  parameter int   BP      = 64,
  parameter logic POL     = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_adv,
  output logic [CW-1:0] count,
  output scan_phase_t   phase,
  output logic          sync,
  output logic          visible,
  output logic          wrap
);

  localparam int TOTAL = axis_total(VISIBLE, FP, SYNC, BP);

  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] FP_START   = CW'(VISIBLE);
  localparam logic [CW-1:0] SYNC_START = CW'(VISIBLE + FP);
  localparam logic [CW-1:0] BP_START   = CW'(VISIBLE + FP + SYNC);

  logic [CW-1:0] count_nxt;
  scan_phase_t   phase_nxt;

  assign wrap = i_adv && (count == LAST);

  // Next position and next phase; phase steps when the new count crosses a boundary.
  always_comb begin
    count_nxt = count;
    phase_nxt = phase;
    if (i_adv) begin
      count_nxt = (count == LAST) ? '0 : count + CW'(1);
      case (phase)
        PH_ACTIVE: if (count_nxt == FP_START)   phase_nxt = PH_FRONT;
        PH_FRONT:  if (count_nxt == SYNC_START) phase_nxt = PH_SYNC;
        PH_SYNC:   if (count_nxt == BP_START)   phase_nxt = PH_BACK;
        PH_BACK:   if (count_nxt == '0)         phase_nxt = PH_ACTIVE;
        default:   phase_nxt = PH_BACK;
      endcase
    end
  end

  // Register count, phase and the decoded sync/visible flags from the next state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count   <= LAST;
      phase   <= PH_BACK;
      sync    <= ~POL;
      visible <= 1'b0;
    end else begin
      count   <= count_nxt;
      phase   <= phase_nxt;
      sync    <= (phase_nxt == PH_SYNC) ? POL : ~POL;
      visible <= (phase_nxt == PH_ACTIVE);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel strobe, beam coordinates, display enable,
// hsync/vsync and frame-start pulse. Default geometry is SVGA 800x600.
// Optional macro VGA_SYNC_DELAY_EN delays hsync, vsync and display enable by
// SYNC_DELAY pixel strobes to line up with pixel generators that register ROM reads.
//
// Handshake: there is no valid/ready pair; o_pix_stb is a one-clk qualifier and
// every coordinate/sync output is stable between strobes. i_en low freezes all state.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV    = 2,
  parameter int   H_VISIBLE  = SVGA_H_VISIBLE,
  parameter int   H_FP       = SVGA_H_FP,
  parameter int   H_SYNC     = SVGA_H_SYNC,
  parameter int   H_BP       = SVGA_H_BP,
  parameter int   V_VISIBLE  = SVGA_V_VISIBLE,
  parameter int   V_FP       = SVGA_V_FP,
  parameter int   V_SYNC     = SVGA_V_SYNC,
  parameter int   V_BP       = SVGA_V_BP,
  parameter logic H_SYNC_POL = 1'b1,
  parameter logic V_SYNC_POL = 1'b1,
  parameter int   SYNC_DELAY = 2
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_en,
  output logic     o_pix_stb,
  output h_coord_t o_h_coord,
  output v_coord_t o_v_coord,
  output logic     o_disp_enbl,
  output logic     o_hsync,
  output logic     o_vsync,
  output logic     o_frame_start
);

  localparam int H_TOTAL = axis_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_VISIBLE, V_FP, V_SYNC, V_BP);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Elaboration-time guards on the geometry and divider.
  if (H_TOTAL > 2048) begin : g_chk_h_total
    $error("H_TOTAL exceeds the 11-bit horizontal coordinate");
  end
  if (V_TOTAL > 1024) begin : g_chk_v_total
    $error("V_TOTAL exceeds the 10-bit vertical coordinate");
  end
  if (CLK_DIV < 1) begin : g_chk_div
    $error("CLK_DIV must be at least 1");
  end
  if (SYNC_DELAY < 1) begin : g_chk_dly
    $error("SYNC_DELAY must be at least 1");
  end

  logic [DIV_W-1:0] div_q;
  logic             pix_stb;
  h_coord_t         h_count;
  v_coord_t         v_count;
  scan_phase_t      h_phase;
  scan_phase_t      v_phase;
  logic             h_sync;
  logic             v_sync;
  logic             h_vis;
  logic             v_vis;
  logic             h_wrap;
  logic             v_wrap;
  logic             frame_q;
  logic             disp;

  // Strobe is masked by reset so it reads 0 in the reset state even when CLK_DIV=1.
  assign pix_stb = i_en && !i_rst && (div_q == DIV_LAST);

  // Pixel clock divider; holds its count while the scan is disabled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_q <= '0;
    end else if (i_en) begin
      div_q <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end
  end

  vga_axis_counter #(
    .CW(11), .VISIBLE(H_VISIBLE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_SYNC_POL)
  ) u_h_axis (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_adv   (pix_stb),
    .count   (h_count),
    .phase   (h_phase),
    .sync    (h_sync),
    .visible (h_vis),
    .wrap    (h_wrap)
  );

  vga_axis_counter #(
    .CW(10), .VISIBLE(V_VISIBLE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_SYNC_POL)
  ) u_v_axis (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_adv   (h_wrap),
    .count   (v_count),
    .phase   (v_phase),
    .sync    (v_sync),
    .visible (v_vis),
    .wrap    (v_wrap)
  );

  // Frame start is flagged in the same edge that moves the beam to (0,0).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      frame_q <= 1'b0;
    end else begin
      frame_q <= v_wrap;
    end
  end

  // Visible flags and phases are two views of the same FSM state; keep them consistent.
  always @(posedge i_clk) begin
    if (!i_rst) begin
      assert ((h_vis == (h_phase == PH_ACTIVE)) && (v_vis == (v_phase == PH_ACTIVE)));
    end
  end

  assign disp          = h_vis && v_vis;
  assign o_pix_stb     = pix_stb;
  assign o_h_coord     = h_count;
  assign o_v_coord     = v_count;
  assign o_frame_start = frame_q && i_en;

`ifdef VGA_SYNC_DELAY_EN
  logic [SYNC_DELAY-1:0] hs_sr;
  logic [SYNC_DELAY-1:0] vs_sr;
  logic [SYNC_DELAY-1:0] de_sr;

  // Sync/enable delay line, advanced once per pixel strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hs_sr <= {SYNC_DELAY{~H_SYNC_POL}};
      vs_sr <= {SYNC_DELAY{~V_SYNC_POL}};
      de_sr <= '0;
    end else if (pix_stb) begin
      hs_sr[0] <= h_sync;
      vs_sr[0] <= v_sync;
      de_sr[0] <= disp;
      for (int i = 1; i < SYNC_DELAY; i++) begin
        hs_sr[i] <= hs_sr[i-1];
        vs_sr[i] <= vs_sr[i-1];
        de_sr[i] <= de_sr[i-1];
      end
    end
  end

  assign o_hsync     = hs_sr[SYNC_DELAY-1];
  assign o_vsync     = vs_sr[SYNC_DELAY-1];
  assign o_disp_enbl = de_sr[SYNC_DELAY-1];
`else
  assign o_hsync     = h_sync;
  assign o_vsync     = v_sync;
  assign o_disp_enbl = disp;
`endif

endmodule
